// File: rtl/cam_pkg.sv
// Shared constants and helpers for the cam block.
// Pointer wrap helper supports any depth, not only powers of two.
package cam_pkg;

   localparam int CAM_WIDTH_DEF = 8;
   localparam int CAM_DEPTH_DEF = 16;

   function automatic int unsigned cam_next_ptr(input int unsigned ptr, input int unsigned depth);
      int unsigned nxt;
      if (ptr == depth - 32'd1) begin
         nxt = 32'd0;
      end else begin
         nxt = ptr + 32'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/cam_entry.sv
// One CAM slot: stored word, valid flag and a combinational equality compare.
// The word itself is never reset; only the valid flag qualifies it.
module cam_entry
   import cam_pkg::*;
#(
   parameter int WIDTH = CAM_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [WIDTH-1:0] data_in,
   output logic             hit
);

   logic [WIDTH-1:0] word_r;
   logic             valid_r;

   // Word storage, loaded on a decoded write.
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         word_r <= data_in;
      end else begin
         word_r <= word_r;
      end
   end

   // Valid flag: cleared by reset, set by any write to this slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
      end else if (we) begin
         valid_r <= 1'b1;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign hit = valid_r && (word_r == data_in);

endmodule

// File: rtl/cam.sv
// Round-robin-fill content-addressable memory with a registered multi-hot match vector.
// Optional build macro CAM_WRITE_DEDUP_EN drops writes whose data already matches a valid entry.
module cam
   import cam_pkg::*;
#(
   parameter int WIDTH = CAM_WIDTH_DEF,
   parameter int DEPTH = CAM_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             wr_en,
   output logic [DEPTH-1:0] match
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]    wr_ptr_r;
   logic [DEPTH-1:0] match_r;
   logic [DEPTH-1:0] hit_s;
   logic [DEPTH-1:0] sel_s;
   logic             wr_accept_s;

   // Decide whether a write cycle actually stores its data.
   always_comb begin
      wr_accept_s = 1'b0;
`ifdef CAM_WRITE_DEDUP_EN
      if (wr_en && (hit_s == {DEPTH{1'b0}})) begin
         wr_accept_s = 1'b1;
      end else begin
         wr_accept_s = 1'b0;
      end
`else
      if (wr_en) begin
         wr_accept_s = 1'b1;
      end else begin
         wr_accept_s = 1'b0;
      end
`endif
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      assign sel_s[g] = wr_accept_s && (wr_ptr_r == PW'(g));

      cam_entry #(
         .WIDTH (WIDTH)
      ) u_entry (
         .clk     (clk),
         .rst     (rst),
         .we      (sel_s[g]),
         .data_in (data_in),
         .hit     (hit_s[g])
      );
   end

   // Write pointer advance and match capture; write cycles clear the match vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         match_r  <= {DEPTH{1'b0}};
      end else if (wr_en) begin
         match_r <= {DEPTH{1'b0}};
         if (wr_accept_s) begin
            wr_ptr_r <= PW'(cam_next_ptr(32'(wr_ptr_r), DEPTH));
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
      end else begin
         wr_ptr_r <= wr_ptr_r;
         match_r  <= hit_s;
      end
   end

   assign match = match_r;

endmodule

// File: tb/tb_cam.sv
// Table-driven directed bench for cam (WIDTH=8, DEPTH=16).
// Expected values adapt when CAM_WRITE_DEDUP_EN is defined.
module tb_cam;

   typedef struct {
      logic        rst;
      logic        wr;
      logic [7:0]  data;
      logic [15:0] exp;
   } vec_t;

`ifdef CAM_WRITE_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_in;
   logic        wr_en;
   logic [15:0] match;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vecs[$];

   cam #(.WIDTH(8), .DEPTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .data_in (data_in),
      .wr_en   (wr_en),
      .match   (match)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic w, input logic [7:0] d, input logic [15:0] e);
      vec_t v;
      v.rst = r; v.wr = w; v.data = d; v.exp = e;
      vecs.push_back(v);
   endtask

   // Drive one cycle, then sample #1 after the rising edge.
   task automatic step(input logic r, input logic w, input logic [7:0] d);
      rst = r; wr_en = w; data_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] exp);
      n_cmp++;
      if (match !== exp) begin
         n_bad++;
         $display("FAIL %s: match=%h expected=%h", name, match, exp);
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; data_in = 8'h00;

      // Reset, then search a stale-zero key.
      add(1'b1, 1'b0, 8'h00, 16'h0000);
      add(1'b1, 1'b0, 8'h00, 16'h0000);
      add(1'b0, 1'b0, 8'h00, 16'h0000);
      // Two writes each of 3F, 7A, C3, 4B; match stays clear during writes.
      add(1'b0, 1'b1, 8'h3F, 16'h0000);
      add(1'b0, 1'b1, 8'h3F, 16'h0000);
      add(1'b0, 1'b1, 8'h7A, 16'h0000);
      add(1'b0, 1'b1, 8'h7A, 16'h0000);
      add(1'b0, 1'b1, 8'hC3, 16'h0000);
      add(1'b0, 1'b1, 8'hC3, 16'h0000);
      add(1'b0, 1'b1, 8'h4B, 16'h0000);
      add(1'b0, 1'b1, 8'h4B, 16'h0000);
      add(1'b0, 1'b0, 8'h3F, DEDUP ? 16'h0001 : 16'h0003);
      add(1'b0, 1'b0, 8'h7A, DEDUP ? 16'h0002 : 16'h000C);
      add(1'b0, 1'b0, 8'hC3, DEDUP ? 16'h0004 : 16'h0030);
      add(1'b0, 1'b0, 8'h4B, DEDUP ? 16'h0008 : 16'h00C0);
      add(1'b0, 1'b0, 8'hAA, 16'h0000);
      // Clear, then 17 distinct writes 10..20 to force wrap-around.
      add(1'b1, 1'b0, 8'h00, 16'h0000);
      for (int i = 0; i < 17; i++) begin
         add(1'b0, 1'b1, 8'(8'h10 + i), 16'h0000);
      end
      add(1'b0, 1'b0, 8'h10, 16'h0000);
      add(1'b0, 1'b0, 8'h20, 16'h0001);
      add(1'b0, 1'b0, 8'h1F, 16'h8000);
      add(1'b0, 1'b0, 8'h12, 16'h0004);
      // Write right after a search: match drops; 55 lands in entry 1, replacing 11.
      add(1'b0, 1'b1, 8'h55, 16'h0000);
      add(1'b0, 1'b0, 8'h55, 16'h0002);
      add(1'b0, 1'b0, 8'h11, 16'h0000);
      // Reset pulse after filling discards everything.
      add(1'b1, 1'b0, 8'h00, 16'h0000);
      add(1'b0, 1'b0, 8'h20, 16'h0000);
      add(1'b0, 1'b0, 8'h55, 16'h0000);
      add(1'b0, 1'b0, 8'h1F, 16'h0000);
      // Next write goes to entry 0 and is visible at the very next edge.
      add(1'b0, 1'b1, 8'h99, 16'h0000);
      add(1'b0, 1'b0, 8'h99, 16'h0001);
      // Duplicate write: stored twice normally, dropped with dedup.
      add(1'b0, 1'b1, 8'h99, 16'h0000);
      add(1'b0, 1'b0, 8'h99, DEDUP ? 16'h0001 : 16'h0003);
      add(1'b0, 1'b1, 8'h77, 16'h0000);
      add(1'b0, 1'b0, 8'h77, DEDUP ? 16'h0002 : 16'h0004);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].wr, vecs[i].data);
         check($sformatf("vec[%0d] rst=%0b wr=%0b d=%h", i, vecs[i].rst, vecs[i].wr, vecs[i].data),
               vecs[i].exp);
      end

      // Reset wins over a simultaneous write; the next write then lands at entry 0.
      step(1'b1, 1'b1, 8'h66);
      check("rst_prio_match", 16'h0000);
      step(1'b0, 1'b0, 8'h66);
      check("rst_prio_not_stored", 16'h0000);
      step(1'b0, 1'b1, 8'hE1);
      check("post_rst_write", 16'h0000);
      step(1'b0, 1'b0, 8'hE1);
      check("post_rst_entry0", 16'h0001);

      // Search held for several cycles keeps reporting the same hit.
      step(1'b0, 1'b0, 8'hE1);
      check("held_search", 16'h0001);
      step(1'b0, 1'b0, 8'h00);
      check("held_then_miss", 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
